// File: rtl/control_signal_decoder_pkg.sv
// rtl/control_signal_decoder_pkg.sv - microinstruction field map and decoded control word layout
package control_signal_decoder_pkg;

    localparam int NUM_REGS = 12;
    localparam logic [3:0] REG_CODE_FROM_IR = 4'hF;

    localparam int NXTADD_LSB  = 31;
    localparam int ALUCTRL_LSB = 28;
    localparam int ALUMUX_LSB  = 25;
    localparam int WSEL_LSB    = 21;
    localparam int RSEL_LSB    = 17;
    localparam int MISC_LSB    = 13;
    localparam int DIRECT_LSB  = 7;
    localparam int S3_LSB      = 5;
    localparam int S8_LSB      = 1;

    // Field order matches the 56-bit concatenated output, MSB first.
    typedef struct packed {
        logic [3:0]          misc;
        logic [NUM_REGS-1:0] reg_wr_en;
        logic [NUM_REGS-1:0] reg_rd_en;
        logic [5:0]          direct;
        logic [2:0]          sel3_en;
        logic [7:0]          sel8_en;
        logic [2:0]          alumux;
        logic [2:0]          aluctrl;
        logic [4:0]          nxtadd;
    } ctrl_word_t;

    function automatic logic [7:0] decode_s8(input logic [3:0] code);
        logic [7:0] en;
        en = '0;
        if (code != 4'd0 && code <= 4'd8) begin
            en = 8'd1 << (code - 4'd1);
        end
        return en;
    endfunction

endpackage

// File: rtl/control_signal_decoder_reg_code_decoder.sv
// rtl/control_signal_decoder_reg_code_decoder.sv - register code to one-hot enable, code 15 defers to the IR field
module reg_code_decoder
    import control_signal_decoder_pkg::*;
(
    input  logic [3:0]          code,
    input  logic [3:0]          ir_code,
    output logic [NUM_REGS-1:0] en
);

    logic [3:0] eff_code;

    always_comb begin
        eff_code = (code == REG_CODE_FROM_IR) ? ir_code : code;
        en = '0;
        // Codes 0 and 13..15 select no register, including after IR substitution.
        if (eff_code != 4'd0 && eff_code <= 4'(NUM_REGS)) begin
            en = NUM_REGS'(1) << (eff_code - 4'd1);
        end
    end

endmodule

// File: rtl/control_signal_decoder.sv
// rtl/control_signal_decoder.sv - microcode decode stage producing registered datapath controls
module control_signal_decoder
    import control_signal_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [35:0]         ROMIN,
    input  logic [3:0]          WR,
    input  logic [3:0]          RR,
    output logic [3:0]          misc,
    output logic [NUM_REGS-1:0] reg_wr_en,
    output logic [NUM_REGS-1:0] reg_rd_en,
    output logic [5:0]          direct,
    output logic [2:0]          sel3_en,
    output logic [7:0]          sel8_en,
    output logic [2:0]          ALUMUX,
    output logic [2:0]          ALUCTRL,
    output logic [4:0]          NXTADD
);

    ctrl_word_t          d, q;
    logic [NUM_REGS-1:0] wr_dec, rd_dec;
    logic [1:0]          s3_code;
    logic                unused_reserved;

    assign unused_reserved = ROMIN[0];
    assign s3_code         = ROMIN[S3_LSB +: 2];

    reg_code_decoder u_wr_dec (
        .code    (ROMIN[WSEL_LSB +: 4]),
        .ir_code (WR),
        .en      (wr_dec)
    );

    reg_code_decoder u_rd_dec (
        .code    (ROMIN[RSEL_LSB +: 4]),
        .ir_code (RR),
        .en      (rd_dec)
    );

    always_comb begin
        d           = '0;
        d.nxtadd    = ROMIN[NXTADD_LSB +: 5];
        d.aluctrl   = ROMIN[ALUCTRL_LSB +: 3];
        d.alumux    = ROMIN[ALUMUX_LSB +: 3];
        d.misc      = ROMIN[MISC_LSB +: 4];
        d.direct    = ROMIN[DIRECT_LSB +: 6];
        d.reg_wr_en = wr_dec;
        d.reg_rd_en = rd_dec;
        d.sel8_en   = decode_s8(ROMIN[S8_LSB +: 4]);
        if (s3_code != 2'd0) begin
            d.sel3_en = 3'd1 << (s3_code - 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign misc      = q.misc;
    assign reg_wr_en = q.reg_wr_en;
    assign reg_rd_en = q.reg_rd_en;
    assign direct    = q.direct;
    assign sel3_en   = q.sel3_en;
    assign sel8_en   = q.sel8_en;
    assign ALUMUX    = q.alumux;
    assign ALUCTRL   = q.aluctrl;
    assign NXTADD    = q.nxtadd;

endmodule

// File: tb/tb_control_signal_decoder.sv
// tb/tb_control_signal_decoder.sv - self-checking bench for control_signal_decoder
module tb_control_signal_decoder;

    logic        clk;
    logic        reset;
    logic [35:0] ROMIN;
    logic [3:0]  WR;
    logic [3:0]  RR;
    logic [3:0]  misc;
    logic [11:0] reg_wr_en;
    logic [11:0] reg_rd_en;
    logic [5:0]  direct;
    logic [2:0]  sel3_en;
    logic [7:0]  sel8_en;
    logic [2:0]  ALUMUX;
    logic [2:0]  ALUCTRL;
    logic [4:0]  NXTADD;
    logic [55:0] obs;

    int n_cmp;
    int n_err;

    control_signal_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .ROMIN     (ROMIN),
        .WR        (WR),
        .RR        (RR),
        .misc      (misc),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .direct    (direct),
        .sel3_en   (sel3_en),
        .sel8_en   (sel8_en),
        .ALUMUX    (ALUMUX),
        .ALUCTRL   (ALUCTRL),
        .NXTADD    (NXTADD)
    );

    assign obs = {misc, reg_wr_en, reg_rd_en, direct, sel3_en, sel8_en, ALUMUX, ALUCTRL, NXTADD};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input int nxt, input int actl, input int amux,
                                       input int wsel, input int rsel, input int mi,
                                       input int dir, input int s3, input int s8);
        return {nxt[4:0], actl[2:0], amux[2:0], wsel[3:0], rsel[3:0], mi[3:0],
                dir[5:0], s3[1:0], s8[3:0], 1'b0};
    endfunction

    // Reference: register codes select register 1..12, code 15 borrows the IR field.
    function automatic logic [11:0] reg_onehot(input int sel, input int ir);
        logic [11:0] r;
        int eff;
        r = '0;
        eff = (sel == 15) ? ir : sel;
        for (int i = 1; i <= 12; i++) if (eff == i) r[i-1] = 1'b1;
        return r;
    endfunction

    function automatic logic [55:0] model(input logic [35:0] w, input logic [3:0] wr, input logic [3:0] rr);
        logic [2:0] s3;
        logic [7:0] s8;
        int s3c, s8c;
        s3c = int'(w[6:5]);
        s8c = int'(w[4:1]);
        s3 = '0;
        s8 = '0;
        for (int i = 1; i <= 3; i++) if (s3c == i) s3[i-1] = 1'b1;
        for (int i = 1; i <= 8; i++) if (s8c == i) s8[i-1] = 1'b1;
        return {w[16:13], reg_onehot(int'(w[24:21]), int'(wr)), reg_onehot(int'(w[20:17]), int'(rr)),
                w[12:7], s3, s8, w[27:25], w[30:28], w[35:31]};
    endfunction

    task automatic step(input logic [35:0] w, input logic [3:0] wr, input logic [3:0] rr, input logic rst);
        ROMIN = w;
        WR    = wr;
        RR    = rr;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step({36{1'b1}}, 4'hF, 4'hF, 1'b1);
            n_cmp++;
            if (obs !== 56'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 56'd0);
            end
        end
        step(36'd0, 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if (obs !== 56'd0) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, 56'd0);
        end
    endtask

    task automatic test_passthrough();
        step(mk(5'b10101, 3'b011, 3'b110, 0, 0, 0, 0, 0, 0), 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if ({NXTADD, ALUCTRL, ALUMUX} !== {5'h15, 3'd3, 3'd6}) begin
            n_err++;
            $display("FAIL passthrough_fields: got %h/%0d/%0d want 15/3/6", NXTADD, ALUCTRL, ALUMUX);
        end
        n_cmp++;
        if (obs[55:11] !== 45'd0) begin
            n_err++;
            $display("FAIL passthrough_strobes: got %h want 0", obs[55:11]);
        end
    endtask

    task automatic test_reg_ir();
        step(mk(0, 0, 0, 15, 15, 0, 0, 0, 0), 4'b1100, 4'b0001, 1'b0);
        n_cmp++;
        if (reg_wr_en !== 12'h800 || reg_rd_en !== 12'h001) begin
            n_err++;
            $display("FAIL reg_from_ir: got wr %h rd %h want 800 001", reg_wr_en, reg_rd_en);
        end
        step(mk(0, 0, 0, 15, 15, 0, 0, 0, 0), 4'd0, 4'd13, 1'b0);
        n_cmp++;
        if (reg_wr_en !== 12'h000 || reg_rd_en !== 12'h000) begin
            n_err++;
            $display("FAIL reg_from_ir_invalid: got wr %h rd %h want 000 000", reg_wr_en, reg_rd_en);
        end
    endtask

    task automatic test_reg_direct();
        step(mk(0, 0, 0, 3, 12, 0, 0, 0, 0), 4'h5, 4'h5, 1'b0);
        n_cmp++;
        if (reg_wr_en !== 12'h004 || reg_rd_en !== 12'h800) begin
            n_err++;
            $display("FAIL reg_direct: got wr %h rd %h want 004 800", reg_wr_en, reg_rd_en);
        end
        step(mk(0, 0, 0, 13, 0, 0, 0, 0, 0), 4'h5, 4'h5, 1'b0);
        n_cmp++;
        if (reg_wr_en !== 12'h000 || reg_rd_en !== 12'h000) begin
            n_err++;
            $display("FAIL reg_direct_none: got wr %h rd %h want 000 000", reg_wr_en, reg_rd_en);
        end
        step(mk(0, 0, 0, 7, 7, 0, 0, 0, 0), 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if (reg_wr_en !== 12'h040 || reg_rd_en !== 12'h040) begin
            n_err++;
            $display("FAIL reg_same_reg: got wr %h rd %h want 040 040", reg_wr_en, reg_rd_en);
        end
    endtask

    task automatic test_strobes();
        step(mk(0, 0, 0, 0, 0, 4'b1010, 6'b100001, 2'b10, 8), 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if ({misc, direct, sel3_en, sel8_en} !== {4'hA, 6'h21, 3'b010, 8'h80}) begin
            n_err++;
            $display("FAIL strobes: got %h %h %b %h want a 21 010 80", misc, direct, sel3_en, sel8_en);
        end
        step(mk(0, 0, 0, 0, 0, 4'b1010, 6'b100001, 2'b11, 9), 4'h0, 4'h0, 1'b0);
        n_cmp++;
        if (sel8_en !== 8'h00 || sel3_en !== 3'b100) begin
            n_err++;
            $display("FAIL s8_out_of_range: got s3 %b s8 %h want 100 00", sel3_en, sel8_en);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] w;
        logic [3:0]  wr, rr;
        logic        rst;
        logic [55:0] exp_v;
        for (int c = 0; c < 4; c++) begin
            w   = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            wr  = 4'($urandom);
            rr  = 4'($urandom);
            rst = (c == 2);
            exp_v = rst ? 56'd0 : model(w, wr, rr);
            step(w, wr, rr, rst);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] w;
        logic [3:0]  wr, rr;
        logic        rst;
        logic [55:0] exp_v;
        for (int c = 0; c < 300; c++) begin
            w   = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
            if ($urandom_range(0, 3) == 0) w[24:21] = 4'hF;
            if ($urandom_range(0, 3) == 0) w[20:17] = 4'hF;
            wr  = 4'($urandom);
            rr  = 4'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            exp_v = rst ? 56'd0 : model(w, wr, rr);
            step(w, wr, rr, rst);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        ROMIN = '1;
        WR    = 4'h0;
        RR    = 4'h0;
        #2;
        test_reset();
        test_passthrough();
        test_reg_ir();
        test_reg_direct();
        test_strobes();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_signal_decoder.md
Name:
control_signal_decoder

Overview:
- Microcode decode stage of the processor control unit.
- Takes the 36-bit microinstruction read from the control ROM plus the instruction's write-register (WR) and read-register (RR) fields.
- Produces registered datapath control strobes, ALU mux/control codes and the next microcode address.
- Sits between the control-store ROM and the datapath; NXTADD feeds back to the microsequencer.

Parameters:
- None. Field layout and register count (12) are fixed.

Ports:
- clk       in   1   system clock, rising-edge active
- reset     in   1   synchronous, active-high reset
- ROMIN     in   36  microinstruction word
- WR        in   4   write-register code from the instruction register
- RR        in   4   read-register code from the instruction register
- misc      out  4   direct control strobes
- reg_wr_en out  12  one-hot register write enables; bit i = register code i+1
- reg_rd_en out  12  one-hot register bus-read enables; bit i = register code i+1
- direct    out  6   direct control strobes (increment/clear group)
- sel3_en   out  3   one-hot group A
- sel8_en   out  8   one-hot group B
- ALUMUX    out  3   ALU operand mux select
- ALUCTRL   out  3   ALU operation code
- NXTADD    out  5   next microinstruction address
- Concatenated output order, MSB first (56 bits): {misc, reg_wr_en, reg_rd_en, direct, sel3_en, sel8_en, ALUMUX, ALUCTRL, NXTADD}.

Behaviour:
- ROMIN field map:
  - [35:31] NXTADD
  - [30:28] ALUCTRL
  - [27:25] ALUMUX
  - [24:21] WSEL
  - [20:17] RSEL
  - [16:13] misc[3:0]
  - [12:7] direct[5:0]
  - [6:5] S3 code
  - [4:1] S8 code
  - [0] reserved, ignored
- All outputs are registered and update on the rising edge of clk. Latency is 1 cycle: inputs sampled at edge N appear after edge N.
- reset=1 at a rising edge forces every output to 0, all 56 bits. Reset has priority over decode. Asserting reset mid-stream clears outputs on the next edge; decode resumes on the first edge with reset=0.
- NXTADD, ALUCTRL, ALUMUX, misc and direct are copied unchanged from their fields.
- WSEL decode:
  - 0 → reg_wr_en = 0.
  - 1..12 → reg_wr_en[WSEL-1] = 1, all other bits 0.
  - 15 → apply the same rule using WR as the code.
  - 13, 14 → 0.
  - WR of 0 or 13..15 (when WSEL=15) → 0.
- RSEL decode: identical rule using RR, driving reg_rd_en.
- At most one bit set in each of reg_wr_en and reg_rd_en. A write and a read of the same register in one word is legal; both enables assert.
- S3 decode: 00 → none; 01 → sel3_en[0]; 10 → sel3_en[1]; 11 → sel3_en[2].
- S8 decode: 0 → none; 1..8 → sel8_en[code-1]; 9..15 → none.
- No handshake; a new word is accepted every cycle.
- Outputs never go X after the first edge in which reset or the inputs are known.

Decomposition:
- Shared package holds:
  - field bit-position constants (NXTADD_LSB, WSEL_LSB, etc.)
  - NUM_REGS = 12
  - REG_CODE_FROM_IR = 4'hF
  - the 56-bit output struct ordering.
- Natural sub-module: reg_code_decoder, a 4-bit code to 12-bit one-hot decoder with the "15 = use IR field" substitution. Instantiate it twice, once for write and once for read.
- The rest is flat combinational decode plus one output register stage.

Test Plan:
1. reset=1 for 2 edges with ROMIN = all ones → all 56 output bits 0. Release reset with ROMIN = 0 → outputs remain 0.
2. ROMIN with NXTADD=10101, ALUCTRL=011, ALUMUX=110, all other fields 0 → after 1 edge: NXTADD=5'h15, ALUCTRL=3, ALUMUX=6, every strobe 0.
3. WSEL=F, RSEL=F, WR=4'b1100, RR=4'b0001 → reg_wr_en=12'h800, reg_rd_en=12'h001.
4. WSEL=3, RSEL=12, then WSEL=13, RSEL=0 → first 12'h004 / 12'h800, then both 0.
5. misc=1010, direct=100001, S3=10, S8=1000 → misc=4'hA, direct=6'h21, sel3_en=3'b010, sel8_en=8'h80. Then S8=9 → sel8_en=0.
6. Run back-to-back words over 4 cycles, asserting reset in cycle 3 → each output equals the decode of the previous cycle's input, except the cycle after reset, which is all zero.
